// File: rtl/gin_scheduler.sv
// rtl/gin_scheduler.sv - GIN sequencer: loads Y/X ID scan chains, then streams tagged SRAM words into the GIN
// Optional feature macro: GIN_SCHED_STALL_CNT_EN (GIN backpressure cycle counter on stall_cnt)
module gin_scheduler #(
    parameter int NUM_ROW   = 6,
    parameter int NUM_COL   = 8,
    parameter int XID_BITS  = 5,
    parameter int YID_BITS  = 4,
    parameter int DATA_BITS = 32
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [NUM_ROW*YID_BITS-1:0]          yid_table,
    input  logic [NUM_ROW*NUM_COL*XID_BITS-1:0]  xid_table,
    input  logic [YID_BITS:0]                    y_len,
    input  logic [XID_BITS:0]                    x_len,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 set_YID,
    output logic [YID_BITS-1:0]                  YID_scan_in,
    output logic                                 set_XID,
    output logic [XID_BITS-1:0]                  XID_scan_in,
    input  logic                                 src_valid,
    output logic                                 src_ready,
    input  logic [DATA_BITS-1:0]                 src_data,
    output logic                                 GIN_valid,
    input  logic                                 GIN_ready,
    output logic [DATA_BITS-1:0]                 GIN_data,
    output logic [YID_BITS-1:0]                  tag_Y,
    output logic [XID_BITS-1:0]                  tag_X,
    output logic [15:0]                          stall_cnt
);

    localparam int NUM_PE = NUM_ROW * NUM_COL;
    localparam int CNT_W  = $clog2(NUM_PE);
    localparam int YTAB_W = NUM_ROW * YID_BITS;
    localparam int XTAB_W = NUM_PE * XID_BITS;
    localparam logic [CNT_W-1:0]  Y_LAST = CNT_W'(NUM_ROW - 1);
    localparam logic [CNT_W-1:0]  X_LAST = CNT_W'(NUM_PE - 1);
    localparam logic [XID_BITS:0] X_ONE  = (XID_BITS+1)'(1);
    localparam logic [YID_BITS:0] Y_ONE  = (YID_BITS+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN_Y,
        S_SCAN_X,
        S_STREAM,
        S_DONE
    } state_t;

    state_t              r_state;
    // Latched tables are shifted left while scanning so the top slice is always the next ID out
    logic [YTAB_W-1:0]   r_ytab;
    logic [XTAB_W-1:0]   r_xtab;
    logic [YID_BITS:0]   r_y_len;
    logic [XID_BITS:0]   r_x_len;
    logic [CNT_W-1:0]    r_cnt;
    logic [XID_BITS-1:0] r_tag_x;
    logic [YID_BITS-1:0] r_tag_y;

    logic w_stream;
    logic w_xfer;
    logic w_x_last;
    logic w_y_last;
    logic w_empty;

    assign w_stream = (r_state == S_STREAM);
    assign w_xfer   = w_stream & src_valid & GIN_ready;
    assign w_x_last = ({1'b0, r_tag_x} == (r_x_len - X_ONE));
    assign w_y_last = ({1'b0, r_tag_y} == (r_y_len - Y_ONE));
    assign w_empty  = (r_x_len == '0) | (r_y_len == '0);

    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign set_YID     = (r_state == S_SCAN_Y);
    assign set_XID     = (r_state == S_SCAN_X);
    assign YID_scan_in = set_YID ? r_ytab[YTAB_W-1 -: YID_BITS] : '0;
    assign XID_scan_in = set_XID ? r_xtab[XTAB_W-1 -: XID_BITS] : '0;
    assign GIN_valid   = w_stream & src_valid;
    assign src_ready   = w_stream & GIN_ready;
    assign GIN_data    = w_stream ? src_data : '0;
    assign tag_Y       = r_tag_y;
    assign tag_X       = r_tag_x;

    // Job sequencer: latch on start, scan Y then X chains, stream x_len*y_len words, pulse done
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ytab  <= '0;
            r_xtab  <= '0;
            r_y_len <= '0;
            r_x_len <= '0;
            r_cnt   <= '0;
            r_tag_x <= '0;
            r_tag_y <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_ytab  <= yid_table;
                        r_xtab  <= xid_table;
                        r_y_len <= y_len;
                        r_x_len <= x_len;
                        r_cnt   <= '0;
                        r_state <= S_SCAN_Y;
                    end
                end
                S_SCAN_Y: begin
                    r_ytab <= r_ytab << YID_BITS;
                    if (r_cnt == Y_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_SCAN_X;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SCAN_X: begin
                    r_xtab <= r_xtab << XID_BITS;
                    if (r_cnt == X_LAST) begin
                        r_cnt   <= '0;
                        r_state <= w_empty ? S_DONE : S_STREAM;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STREAM: begin
                    if (w_xfer) begin
                        if (w_x_last) begin
                            r_tag_x <= '0;
                            if (w_y_last) begin
                                r_tag_y <= '0;
                                r_state <= S_DONE;
                            end else begin
                                r_tag_y <= r_tag_y + 1'b1;
                            end
                        end else begin
                            r_tag_x <= r_tag_x + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_tag_x <= '0;
                    r_tag_y <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef GIN_SCHED_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of streaming cycles where a valid word is held back by the GIN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_stall_cnt <= '0;
        end else if (GIN_valid && !GIN_ready && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_gin_scheduler.sv
// tb/tb_gin_scheduler.sv - directed self-checking bench for gin_scheduler
module tb_gin_scheduler;

    localparam int NUM_ROW   = 6;
    localparam int NUM_COL   = 8;
    localparam int XID_BITS  = 5;
    localparam int YID_BITS  = 4;
    localparam int DATA_BITS = 32;
    localparam int NUM_PE    = NUM_ROW * NUM_COL;

    logic                               clk = 1'b0;
    logic                               rst;
    logic                               start;
    logic [NUM_ROW*YID_BITS-1:0]        yid_table;
    logic [NUM_PE*XID_BITS-1:0]         xid_table;
    logic [YID_BITS:0]                  y_len;
    logic [XID_BITS:0]                  x_len;
    logic                               busy;
    logic                               done;
    logic                               set_YID;
    logic [YID_BITS-1:0]                YID_scan_in;
    logic                               set_XID;
    logic [XID_BITS-1:0]                XID_scan_in;
    logic                               src_valid;
    logic                               src_ready;
    logic [DATA_BITS-1:0]               src_data;
    logic                               GIN_valid;
    logic                               GIN_ready;
    logic [DATA_BITS-1:0]               GIN_data;
    logic [YID_BITS-1:0]                tag_Y;
    logic [XID_BITS-1:0]                tag_X;
    logic [15:0]                        stall_cnt;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_stall;

    gin_scheduler #(
        .NUM_ROW(NUM_ROW), .NUM_COL(NUM_COL), .XID_BITS(XID_BITS),
        .YID_BITS(YID_BITS), .DATA_BITS(DATA_BITS)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .yid_table(yid_table), .xid_table(xid_table),
        .y_len(y_len), .x_len(x_len),
        .busy(busy), .done(done),
        .set_YID(set_YID), .YID_scan_in(YID_scan_in),
        .set_XID(set_XID), .XID_scan_in(XID_scan_in),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .GIN_valid(GIN_valid), .GIN_ready(GIN_ready), .GIN_data(GIN_data),
        .tag_Y(tag_Y), .tag_X(tag_X), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue a start pulse from IDLE; after return the DUT is in its first SCAN_Y cycle
    task automatic kick(input logic [YID_BITS:0] yl, input logic [XID_BITS:0] xl);
        y_len = yl;
        x_len = xl;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_setY"}, 64'(set_YID), 64'd0);
        chk({tag, "_setX"}, 64'(set_XID), 64'd0);
        chk({tag, "_gvalid"}, 64'(GIN_valid), 64'd0);
        chk({tag, "_sready"}, 64'(src_ready), 64'd0);
        chk({tag, "_tags"}, 64'({tag_Y, tag_X}), 64'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        y_len     = '0;
        x_len     = '0;
        src_valid = 1'b0;
        GIN_ready = 1'b0;
        src_data  = '0;
        // Row r holds Y ID 5-r; PE k holds X ID (47-k) mod 32, so scan order yields i and i mod 32
        for (int r = 0; r < NUM_ROW; r++)
            yid_table[r*YID_BITS +: YID_BITS] = YID_BITS'(NUM_ROW - 1 - r);
        for (int k = 0; k < NUM_PE; k++)
            xid_table[k*XID_BITS +: XID_BITS] = XID_BITS'(NUM_PE - 1 - k);

        // Reset state
        step();
        step();
        check_idle_outputs("reset");
        chk("reset_stall", 64'(stall_cnt), 64'd0);
        rst = 1'b0;
        step();

        // Reset mid-SCAN_X aborts immediately with no done pulse
        kick(3'd2, 4'd3);
        for (int i = 0; i < NUM_ROW + 10; i++) step();
        chk("abort_in_scanx", 64'(set_XID), 64'd1);
        rst = 1'b1;
        #1;
        check_idle_outputs("abort");
        chk("abort_scanx_data", 64'(XID_scan_in), 64'd0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("abort_nodone", 64'(done), 64'd0);
            chk("abort_idle", 64'(busy), 64'd0);
            step();
        end

        // Full job y_len=2 x_len=3, always-ready; start re-pulsed mid-stream must be ignored
        src_valid = 1'b1;
        GIN_ready = 1'b1;
        kick(5'd2, 6'd3);
        for (int i = 0; i < NUM_ROW; i++) begin
            chk("scany_en", 64'(set_YID), 64'd1);
            chk("scany_xen", 64'(set_XID), 64'd0);
            chk("scany_data", 64'(YID_scan_in), 64'(i));
            chk("scany_gvalid", 64'(GIN_valid), 64'd0);
            step();
        end
        for (int i = 0; i < NUM_PE; i++) begin
            chk("scanx_en", 64'(set_XID), 64'd1);
            chk("scanx_yen", 64'(set_YID), 64'd0);
            chk("scanx_data", 64'(XID_scan_in), 64'(i % 32));
            chk("scanx_sready", 64'(src_ready), 64'd0);
            step();
        end
        for (int k = 0; k < 6; k++) begin
            src_data = 32'hA500_0000 + 32'(k);
            start    = (k == 2);
            #1;
            chk("stream_valid", 64'(GIN_valid), 64'd1);
            chk("stream_ready", 64'(src_ready), 64'd1);
            chk("stream_data", 64'(GIN_data), 64'(32'hA500_0000 + 32'(k)));
            chk("stream_tagY", 64'(tag_Y), 64'(k / 3));
            chk("stream_tagX", 64'(tag_X), 64'(k % 3));
            chk("stream_nodone", 64'(done), 64'd0);
            step();
        end
        start = 1'b0;
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd1);
        chk("done_gvalid", 64'(GIN_valid), 64'd0);
        step();
        check_idle_outputs("after_job");

        // Backpressure at (0,1): tags and data held for 4 cycles
        kick(5'd2, 6'd3);
        for (int i = 0; i < NUM_ROW + NUM_PE; i++) step();
        src_data = 32'h1111_0000;
        step();
        src_data  = 32'h2222_0001;
        GIN_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("stall_tags", 64'({tag_Y, tag_X}), 64'({4'd0, 5'd1}));
            chk("stall_sready", 64'(src_ready), 64'd0);
            chk("stall_gvalid", 64'(GIN_valid), 64'd1);
            chk("stall_data", 64'(GIN_data), 64'(32'h2222_0001));
            step();
        end
        GIN_ready = 1'b1;
`ifdef GIN_SCHED_STALL_CNT_EN
        exp_stall = 16'd4;
`else
        exp_stall = 16'd0;
`endif
        #1;
        chk("stall_count", 64'(stall_cnt), 64'(exp_stall));
        chk("resume_tags", 64'({tag_Y, tag_X}), 64'({4'd0, 5'd1}));
        for (int k = 1; k < 6; k++) step();
        chk("stall_job_done", 64'(done), 64'd1);
        chk("stall_count_done", 64'(stall_cnt), 64'(exp_stall));
        step();
        chk("stall_count_idle", 64'(stall_cnt), 64'(exp_stall));

        // x_len=0: scans run, no words, done right after SCAN_X
        kick(5'd3, 6'd0);
        chk("empty_stall_clr", 64'(stall_cnt), 64'd0);
        for (int i = 0; i < NUM_ROW; i++) step();
        for (int i = 0; i < NUM_PE; i++) begin
            chk("empty_scanx", 64'(set_XID), 64'd1);
            step();
        end
        chk("empty_done", 64'(done), 64'd1);
        chk("empty_gvalid", 64'(GIN_valid), 64'd0);
        step();
        check_idle_outputs("empty_after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
